// File: rtl/masked_sbox_drv_pkg.sv
// masked_sbox_drv_pkg
// Shared constants and the single-step LFSR helper for the masked S-box
// share driver. Polynomial 0x80200003, right-shifting Galois form: the bit
// shifted out of position 0 is folded back through the tap mask.
package masked_sbox_drv_pkg;

  localparam int          BYTE_W       = 8;
  localparam int          RAND_W       = 10;
  localparam int          LFSR_W       = 32;
  localparam int          LFSR_STEPS   = 18;
  localparam int          SBOX_LAT_DEF = 3;
  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n = s >> 1;
    if (s[0]) begin
      n = n ^ LFSR_POLY;
    end
    return n;
  endfunction

endpackage

// File: rtl/sbox_drv_lfsr.sv
// sbox_drv_lfsr
// 32-bit Galois LFSR advanced LFSR_STEPS times per clock. Bits [7:0] of the
// state feed the share mask and bits [17:8] the S-box fresh randomness, so
// each cycle's 18 new bits are used exactly once.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset, reloads SEED
//   o_mask  out  8-bit mask taken from the current state
//   o_ran   out  10-bit fresh randomness taken from the current state
module sbox_drv_lfsr
  import masked_sbox_drv_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2024
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [BYTE_W-1:0] o_mask,
  output logic [RAND_W-1:0] o_ran
);

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] w_next;

  // Unrolled: LFSR_STEPS single steps chained combinationally.
  always_comb begin
    w_next = r_state;
    for (int i = 0; i < LFSR_STEPS; i++) begin
      w_next = lfsr_step(w_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else begin
      r_state <= w_next;
    end
  end

  assign o_mask = r_state[BYTE_W-1:0];
  assign o_ran  = r_state[BYTE_W+RAND_W-1:BYTE_W];

endmodule

// File: rtl/masked_sbox_share_driver.sv
// masked_sbox_share_driver
// Two-share Boolean masking harness in front of a free-running masked AES
// S-box with SBOX_LAT cycles of latency. Plain bytes are split into
// (data^mask, mask), in-flight bytes are tracked with a valid shift
// register, and returned shares are buffered in a FIFO. A credit counter
// (in-flight + buffered) throttles admission so the FIFO cannot overflow.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The producer holds valid and its data stable until the transfer; ready
// never depends on valid on the same port. in_ready is decoded from
// registers only.
//
// Optional feature: define MASKED_SBOX_DRV_UNMASK_EN to drive out_data with
// the recombined byte; otherwise out_data is tied to zero and no
// recombination logic exists.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_data  plain byte input handshake
//   sbox_in0/sbox_in1          registered input shares to the S-box
//   sbox_ran                   10 fresh random bits per cycle to the S-box
//   sbox_out0/sbox_out1        output shares returning from the S-box
//   out_valid/out_ready        output handshake
//   out_share0/out_share1      FIFO head shares
//   out_data                   recombined byte or zero
module masked_sbox_share_driver
  import masked_sbox_drv_pkg::*;
#(
  parameter int          SBOX_LAT   = SBOX_LAT_DEF,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic [BYTE_W-1:0] sbox_in0,
  output logic [BYTE_W-1:0] sbox_in1,
  output logic [RAND_W-1:0] sbox_ran,
  input  logic [BYTE_W-1:0] sbox_out0,
  input  logic [BYTE_W-1:0] sbox_out1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_share0,
  output logic [BYTE_W-1:0] out_share1,
  output logic [BYTE_W-1:0] out_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [BYTE_W-1:0] w_mask;
  logic              w_accept;
  logic              w_pop;
  logic              w_fifo_wr;

  logic [BYTE_W-1:0] r_sh0;
  logic [BYTE_W-1:0] r_sh1;
  logic [SBOX_LAT:0] r_vld;
  logic [CNT_W-1:0]  r_occ;
  logic [CNT_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [BYTE_W-1:0] r_mem0 [FIFO_DEPTH];
  logic [BYTE_W-1:0] r_mem1 [FIFO_DEPTH];

  sbox_drv_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_mask (w_mask),
    .o_ran  (sbox_ran)
  );

  assign in_ready  = (r_occ < DEPTH_C);
  assign out_valid = (r_cnt != '0);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  // Bit 0 marks the byte sitting in the share register; bits 1..SBOX_LAT
  // follow it through the S-box stages, so the tail lines up with the
  // cycle its result appears on sbox_out0/1.
  assign w_fifo_wr = r_vld[SBOX_LAT];

  // Idle cycles load a fresh (m, m) pair, an encoding of zero, so the
  // S-box never sees a stale or constant input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh0 <= '0;
      r_sh1 <= '0;
    end else begin
      r_sh0 <= w_accept ? (in_data ^ w_mask) : w_mask;
      r_sh1 <= w_mask;
    end
  end

  assign sbox_in0 = r_sh0;
  assign sbox_in1 = r_sh1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[SBOX_LAT-1:0], w_accept};
    end
  end

  // Credits cover a byte from acceptance until it leaves the FIFO; the
  // in-flight to FIFO handover does not change the total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + CNT_W'(1);
        2'b01:   r_occ <= r_occ - CNT_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem0[i] <= '0;
        r_mem1[i] <= '0;
      end
    end else begin
      if (w_fifo_wr) begin
        r_mem0[r_wr_ptr] <= sbox_out0;
        r_mem1[r_wr_ptr] <= sbox_out1;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_fifo_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign out_share0 = r_mem0[r_rd_ptr];
  assign out_share1 = r_mem1[r_rd_ptr];

`ifdef MASKED_SBOX_DRV_UNMASK_EN
  assign out_data = out_share0 ^ out_share1;
`else
  assign out_data = '0;
`endif

  // Credit admission makes a write into a full, non-popping FIFO unreachable.
  a_no_fifo_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(w_fifo_wr && (r_cnt == DEPTH_C) && !w_pop)
  );

endmodule
